// File: rtl/peripheral_mpi_arbiter_pkg.sv
// Shared types and constants for the MPI buffer bus arbiter.
package peripheral_mpi_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_RELEASE = 2'd2
    } mpi_arb_state_t;

    // Pointer starts at the last requester so requester 0 wins the first search.
    function automatic int unsigned ptr_reset_val(input int unsigned m);
        return m - 1;
    endfunction

endpackage

// File: rtl/peripheral_mpi_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from ptr+1.
module peripheral_mpi_rr_arbiter #(
    parameter int M  = 4,
    parameter int PW = $clog2(M)
) (
    input  logic [M-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [M-1:0]  pick,
    output logic          valid
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= M; i++) begin
            idx = PW'((int'(ptr) + i) % M);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign valid = found;

endmodule

// File: rtl/peripheral_mpi_bus_arbiter.sv
// Round-robin arbiter sharing the MPI buffer bus port among M requesters,
// one transaction per grant, with an optional hung-slave timeout.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | no owner; pick next requester from ptr+1 upward
// ST_ACTIVE  | granted requester drives the bus until ack/err/timeout/abort
// ST_RELEASE | one dead cycle, grant=0, so the owner can drop req_en
module peripheral_mpi_bus_arbiter
    import peripheral_mpi_arbiter_pkg::*;
#(
    parameter int M       = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [M*AW-1:0] req_addr,
    input  logic [M-1:0]  req_we,
    input  logic [M-1:0]  req_en,
    input  logic [M*DW-1:0] req_data_in,
    output logic [DW-1:0] req_data_out,
    output logic [M-1:0]  req_ack,
    output logic [M-1:0]  req_err,
    output logic [M-1:0]  grant,
    output logic [AW-1:0] bus_addr,
    output logic          bus_we,
    output logic          bus_en,
    output logic [DW-1:0] bus_data_in,
    input  logic [DW-1:0] bus_data_out,
    input  logic          bus_ack,
    input  logic          bus_err
);

    localparam int PW = $clog2(M);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT > 0);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [PW-1:0] PTR_RST  = PW'(ptr_reset_val(M));

    mpi_arb_state_t state;
    logic [PW-1:0]  ptr;
    logic [CW-1:0]  cnt;
    logic [M-1:0]   pick;
    logic           pick_valid;
    logic [PW-1:0]  g_idx;
    logic           active;
    logic           en_g;
    logic           abort;
    logic           resp_ack;
    logic           resp_err;
    logic           tmo;

    peripheral_mpi_rr_arbiter #(.M(M), .PW(PW)) u_rr (
        .req   (req_en),
        .ptr   (ptr),
        .pick  (pick),
        .valid (pick_valid)
    );

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < M; i++) begin
            if (grant[i]) g_idx = PW'(i);
        end
    end

    // Priority inside ACTIVE: abort, then err over ack, then timeout.
    assign active   = (state == ST_ACTIVE);
    assign en_g     = req_en[g_idx];
    assign abort    = active && !en_g;
    assign resp_err = active && en_g && bus_err;
    assign resp_ack = active && en_g && bus_ack && !bus_err;
    assign tmo      = TMO_EN && active && en_g && !bus_ack && !bus_err && (cnt >= CNT_LAST);

    assign bus_en       = active && en_g && !tmo;
    assign bus_we       = active ? req_we[g_idx] : 1'b0;
    assign bus_addr     = active ? req_addr[g_idx*AW +: AW] : '0;
    assign bus_data_in  = active ? req_data_in[g_idx*DW +: DW] : '0;
    assign req_data_out = resp_ack ? bus_data_out : '0;
    assign req_ack      = resp_ack ? grant : '0;
    assign req_err      = (resp_err || tmo) ? grant : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            grant <= '0;
            ptr   <= PTR_RST;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant <= pick;
                        cnt   <= '0;
                        state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (abort) begin
                        ptr   <= g_idx;
                        grant <= '0;
                        state <= ST_IDLE;
                    end else if (resp_ack || resp_err || tmo) begin
                        ptr   <= g_idx;
                        grant <= '0;
                        state <= ST_RELEASE;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RELEASE: state <= ST_IDLE;
                default: begin
                    grant <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_mpi_bus_arbiter.sv
// Directed bench for the MPI bus arbiter (M=4, TIMEOUT=8).
module tb_peripheral_mpi_bus_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic [127:0]  req_addr;
    logic [3:0]    req_we;
    logic [3:0]    req_en;
    logic [127:0]  req_data_in;
    logic [31:0]   req_data_out;
    logic [3:0]    req_ack;
    logic [3:0]    req_err;
    logic [3:0]    grant;
    logic [31:0]   bus_addr;
    logic          bus_we;
    logic          bus_en;
    logic [31:0]   bus_data_in;
    logic [31:0]   bus_data_out;
    logic          bus_ack;
    logic          bus_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    peripheral_mpi_bus_arbiter #(.M(4), .AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_addr     (req_addr),
        .req_we       (req_we),
        .req_en       (req_en),
        .req_data_in  (req_data_in),
        .req_data_out (req_data_out),
        .req_ack      (req_ack),
        .req_err      (req_err),
        .grant        (grant),
        .bus_addr     (bus_addr),
        .bus_we       (bus_we),
        .bus_en       (bus_en),
        .bus_data_in  (bus_data_in),
        .bus_data_out (bus_data_out),
        .bus_ack      (bus_ack),
        .bus_err      (bus_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after a rising edge with rst released (cycle 0, IDLE).
    task automatic do_reset();
        rst          = 1'b0;
        req_addr     = '0;
        req_we       = '0;
        req_en       = '0;
        req_data_in  = '0;
        bus_data_out = '0;
        bus_ack      = 1'b0;
        bus_err      = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        req_en  = 4'hF;
        req_addr = {4{32'h1234_5678}};
        req_data_in = {4{32'h55AA_55AA}};
        bus_ack = 1'b1;
        bus_data_out = 32'hFFFF_FFFF;
        repeat (3) tick();
        if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got %b want 0000", grant); end
        total++;
        if (bus_en !== 1'b0) begin bad++; $display("FAIL reset_bus_en got %b want 0", bus_en); end
        total++;
        if (req_ack !== 4'b0000) begin bad++; $display("FAIL reset_req_ack got %b want 0000", req_ack); end
        total++;
        if (bus_addr !== 32'h0) begin bad++; $display("FAIL reset_bus_addr got %h want 0", bus_addr); end
        total++;
        if (req_data_out !== 32'h0) begin bad++; $display("FAIL reset_data_out got %h want 0", req_data_out); end
        total++;
    endtask

    task automatic test_single();
        do_reset();
        req_en = 4'b0100;
        req_we = 4'b0100;
        req_addr[2*32 +: 32]    = 32'h4;
        req_data_in[2*32 +: 32] = 32'hA5;
        #1;
        if (bus_en !== 1'b0 || grant !== 4'b0000) begin
            bad++; $display("FAIL single_c0 got en=%b grant=%b want en=0 grant=0000", bus_en, grant);
        end
        total++;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 3) bus_ack = 1'b1;
            #1;
            if (grant !== 4'b0100 || bus_en !== 1'b1 || bus_we !== 1'b1 ||
                bus_addr !== 32'h4 || bus_data_in !== 32'hA5) begin
                bad++;
                $display("FAIL single_bus c%0d got grant=%b en=%b we=%b addr=%h data=%h want 0100/1/1/4/a5",
                         c, grant, bus_en, bus_we, bus_addr, bus_data_in);
            end
            total++;
        end
        if (req_ack !== 4'b0100 || req_err !== 4'b0000) begin
            bad++; $display("FAIL single_ack got ack=%b err=%b want 0100/0000", req_ack, req_err);
        end
        total++;
        tick();
        bus_ack = 1'b0;
        req_en  = 4'b0000;
        #1;
        if (grant !== 4'b0000 || bus_en !== 1'b0) begin
            bad++; $display("FAIL single_release got grant=%b en=%b want 0000/0", grant, bus_en);
        end
        total++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        do_reset();
        req_en = 4'hF;
        for (int s = 0; s < 5; s++) begin
            exp_g = 4'b0001 << (s % 4);
            tick();
            bus_ack = 1'b1;
            #1;
            if (grant !== exp_g || req_ack !== exp_g) begin
                bad++; $display("FAIL rr_slot%0d got grant=%b ack=%b want %b", s, grant, req_ack, exp_g);
            end
            total++;
            tick();
            bus_ack = 1'b0;
            req_en  = req_en & ~exp_g;
            #1;
            if (grant !== 4'b0000) begin
                bad++; $display("FAIL rr_release%0d got grant=%b want 0000", s, grant);
            end
            total++;
            tick();
            req_en = 4'hF;
        end
    endtask

    task automatic test_read_err();
        do_reset();
        req_en = 4'b0010;
        tick();
        tick();
        bus_data_out = 32'hDEAD_BEEF;
        bus_ack      = 1'b1;
        #1;
        if (req_data_out !== 32'hDEAD_BEEF || req_ack !== 4'b0010 || req_err !== 4'b0000) begin
            bad++; $display("FAIL read_data got data=%h ack=%b err=%b want deadbeef/0010/0000",
                            req_data_out, req_ack, req_err);
        end
        total++;
        tick();
        bus_ack = 1'b0;
        req_en  = 4'b0000;
        tick();
        req_en = 4'b0010;
        tick();
        bus_ack = 1'b1;
        bus_err = 1'b1;
        #1;
        if (grant !== 4'b0010 || req_err !== 4'b0010 || req_ack !== 4'b0000) begin
            bad++; $display("FAIL err_prec got grant=%b err=%b ack=%b want 0010/0010/0000",
                            grant, req_err, req_ack);
        end
        total++;
        tick();
        bus_ack = 1'b0;
        bus_err = 1'b0;
        req_en  = 4'b0000;
    endtask

    task automatic test_timeout();
        do_reset();
        req_en = 4'b0001;
        for (int c = 1; c <= 7; c++) begin
            tick();
            #1;
            if (bus_en !== 1'b1 || req_err !== 4'b0000) begin
                bad++; $display("FAIL tmo_wait c%0d got en=%b err=%b want 1/0000", c, bus_en, req_err);
            end
            total++;
        end
        tick();
        #1;
        if (req_err !== 4'b0001 || bus_en !== 1'b0 || grant !== 4'b0001) begin
            bad++; $display("FAIL tmo_fire got err=%b en=%b grant=%b want 0001/0/0001", req_err, bus_en, grant);
        end
        total++;
        tick();
        bus_ack = 1'b1;
        req_en  = 4'b0000;
        #1;
        if (grant !== 4'b0000 || req_ack !== 4'b0000 || req_err !== 4'b0000 || bus_en !== 1'b0) begin
            bad++; $display("FAIL tmo_late_ack got grant=%b ack=%b err=%b en=%b want all 0",
                            grant, req_ack, req_err, bus_en);
        end
        total++;
        tick();
        bus_ack = 1'b0;
    endtask

    task automatic test_abort();
        do_reset();
        req_en = 4'b1000;
        tick();
        req_en = 4'b1001;
        #1;
        if (grant !== 4'b1000 || bus_en !== 1'b1) begin
            bad++; $display("FAIL abort_grant got grant=%b en=%b want 1000/1", grant, bus_en);
        end
        total++;
        tick();
        req_en = 4'b0001;
        #1;
        if (bus_en !== 1'b0 || req_ack !== 4'b0000 || req_err !== 4'b0000) begin
            bad++; $display("FAIL abort_drop got en=%b ack=%b err=%b want 0/0000/0000", bus_en, req_ack, req_err);
        end
        total++;
        tick();
        bus_ack = 1'b1;
        #1;
        if (grant !== 4'b0000 || req_ack !== 4'b0000) begin
            bad++; $display("FAIL abort_late_ack got grant=%b ack=%b want 0000/0000", grant, req_ack);
        end
        total++;
        tick();
        bus_ack = 1'b0;
        #1;
        if (grant !== 4'b0001 || bus_en !== 1'b1) begin
            bad++; $display("FAIL abort_next got grant=%b en=%b want 0001/1", grant, bus_en);
        end
        total++;
        req_en = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_en = 4'b0100;
        tick();
        tick();
        #2;
        rst     = 1'b0;
        bus_ack = 1'b1;
        #1;
        if (grant !== 4'b0000 || bus_en !== 1'b0 || req_ack !== 4'b0000 || req_err !== 4'b0000) begin
            bad++; $display("FAIL mid_reset got grant=%b en=%b ack=%b err=%b want all 0",
                            grant, bus_en, req_ack, req_err);
        end
        total++;
        tick();
        bus_ack = 1'b0;
        rst     = 1'b1;
        req_en  = 4'b0101;
        tick();
        #1;
        if (grant !== 4'b0001) begin
            bad++; $display("FAIL mid_reset_first got grant=%b want 0001", grant);
        end
        total++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_read_err();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
